// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_t;

  // Timer must hold (largest cycle parameter - 1); never narrower than 1 bit.
  function automatic int timer_width(int rst_cycles, int lock_timeout, int stable_cycles);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int retry_width(int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up / lock supervision sequencer; runs on the board clock and
// releases the downstream system reset only after a qualified stable lock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3,
  parameter int W_LOSS             = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              restart,
  output logic              pll_areset,
  output logic              sys_rst,
  output logic              ready,
  output logic              fail,
  output logic [2:0]        state,
  output logic [W_LOSS-1:0] lock_loss_cnt
);

  localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
  localparam int RW = retry_width(MAX_RETRIES);

  localparam logic [TW-1:0] T_RST_END    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK_END   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STABLE_END = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  seq_state_t        st, st_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [RW-1:0]     retry_cnt, retry_nxt;
  logic [W_LOSS-1:0] loss_cnt, loss_nxt;
  logic              locked_s;
  logic              entry;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    st_nxt    = st;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    entry     = 1'b0;

    if (restart) begin
      // Restart re-enters PLL_RST even from PLL_RST, so the timer restarts too.
      st_nxt    = PLL_RST;
      retry_nxt = '0;
      entry     = 1'b1;
    end else begin
      case (st)
        PLL_RST: begin
          if (timer == T_RST_END) st_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            st_nxt = STABLE;
          end else if (timer == T_LOCK_END) begin
            if (retry_cnt == RETRY_LIMIT) begin
              st_nxt = FAIL;
            end else begin
              st_nxt    = PLL_RST;
              retry_nxt = retry_cnt + RW'(1);
            end
          end
        end
        STABLE: begin
          if (!locked_s) begin
            st_nxt = WAIT_LOCK;
          end else if (timer == T_STABLE_END) begin
            st_nxt    = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            st_nxt = PLL_RST;
            if (loss_cnt != {W_LOSS{1'b1}}) loss_nxt = loss_cnt + W_LOSS'(1);
          end
        end
        FAIL:    st_nxt = FAIL;
        default: st_nxt = PLL_RST;
      endcase
      if (st_nxt != st) entry = 1'b1;
    end

    timer_nxt = entry ? '0 : timer + TW'(1);

    // Moore decode from the state register only.
    pll_areset = (st == PLL_RST) || (st == FAIL);
    sys_rst    = (st != RUN);
    ready      = (st == RUN);
    fail       = (st == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= PLL_RST;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      st        <= st_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
    end
  end

  assign state         = st;
  assign lock_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus pushes expected state transitions (state, cycle,
// loss count); a negedge monitor pops and compares them as the DUT moves.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_areset, sys_rst, ready, fail;
  logic [2:0] state;
  logic [1:0] lock_loss_cnt;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (32),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .W_LOSS             (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .locked        (locked),
    .restart       (restart),
    .pll_areset    (pll_areset),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fail          (fail),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    int         at;
    logic [1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  // {pll_areset, sys_rst, ready, fail} for each state.
  function automatic logic [3:0] outs_of(input logic [2:0] s);
    case (s)
      PLL_RST:   return 4'b1100;
      WAIT_LOCK: return 4'b0100;
      STABLE:    return 4'b0100;
      RUN:       return 4'b0010;
      FAIL:      return 4'b1101;
      default:   return 4'bxxxx;
    endcase
  endfunction

  task automatic push(input logic [2:0] s, input int at, input logic [1:0] c);
    exp_t e;
    e.st = s; e.at = at; e.cnt = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && state !== prev) begin
      if (sb.size() == 0) begin
        chk("unexp_trans", 32'(state), 32'(prev));
      end else begin
        e = sb.pop_front();
        chk("state",    32'(state), 32'(e.st));
        chk("at_cyc",   cyc, e.at);
        chk("outs",     32'({pll_areset, sys_rst, ready, fail}), 32'(outs_of(e.st)));
        chk("loss_cnt", 32'(lock_loss_cnt), 32'(e.cnt));
      end
    end
    prev = state;
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Drop lock in RUN (optionally with a restart on the synced-drop cycle), then recover.
  task automatic drop_recover(input bit rs, input logic [1:0] c);
    int t;
    @(negedge clk);
    t = cyc;
    locked = 1'b0;
    push(PLL_RST, t + 3, c);
    push(WAIT_LOCK, t + 7, c);
    push(STABLE, t + 10, c);
    push(RUN, t + 18, c);
    repeat (2) @(negedge clk);
    restart = rs;
    @(negedge clk);
    restart = 1'b0;
    repeat (4) @(negedge clk);
    locked = 1'b1;
    wait_drain(40);
  endtask

  // Restart with lock absent: three 4-cycle PLL resets 36 cycles apart, then FAIL.
  task automatic never_lock(input logic [1:0] c);
    int s;
    @(negedge clk);
    s = cyc;
    locked  = 1'b0;
    restart = 1'b1;
    push(PLL_RST, s + 1, c);
    push(WAIT_LOCK, s + 5, c);
    push(PLL_RST, s + 37, c);
    push(WAIT_LOCK, s + 41, c);
    push(PLL_RST, s + 73, c);
    push(WAIT_LOCK, s + 77, c);
    push(FAIL, s + 109, c);
    @(negedge clk);
    restart = 1'b0;
    wait_drain(150);
    repeat (5) @(negedge clk);
    chk("fail_sticky", 32'({fail, pll_areset, sys_rst, ready}), 32'(4'b1110));
  endtask

  initial begin
    int r, t, a, s;

    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'(PLL_RST));
    chk("rst_outs",  32'({pll_areset, sys_rst, ready, fail}), 32'(4'b1100));
    chk("rst_loss",  32'(lock_loss_cnt), 0);
    prev   = state;
    mon_en = 1'b1;

    // Clean bring-up; lock rises 10 cycles after reset release.
    rst_n = 1'b1;
    r = cyc;
    push(WAIT_LOCK, r + 4, 2'd0);
    push(STABLE, r + 13, 2'd0);
    push(RUN, r + 21, 2'd0);
    repeat (10) @(negedge clk);
    locked = 1'b1;
    wait_drain(40);

    // Restart coincident with the synced lock drop: no loss counted.
    drop_recover(1'b1, 2'd0);

    // Four losses in RUN: count saturates at 3.
    for (int i = 0; i < 4; i++) drop_recover(1'b0, (i < 3) ? 2'(i + 1) : 2'd3);

    // Glitchy lock while in STABLE.
    @(negedge clk);
    t = cyc;
    locked = 1'b0;
    push(PLL_RST, t + 3, 2'd3);
    push(WAIT_LOCK, t + 7, 2'd3);
    repeat (9) @(negedge clk);
    a = cyc;
    locked = 1'b1;
    push(STABLE, a + 3, 2'd3);
    push(WAIT_LOCK, a + 8, 2'd3);
    push(STABLE, a + 9, 2'd3);
    push(RUN, a + 17, 2'd3);
    repeat (5) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    wait_drain(40);

    // Never locks, then again from FAIL (full retry budget proves retry_cnt cleared).
    never_lock(2'd3);
    never_lock(2'd3);

    // Restart from FAIL with lock present, then async reset during STABLE.
    @(negedge clk);
    s = cyc;
    locked  = 1'b1;
    restart = 1'b1;
    push(PLL_RST, s + 1, 2'd3);
    push(WAIT_LOCK, s + 5, 2'd3);
    push(STABLE, s + 6, 2'd3);
    @(negedge clk);
    restart = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    push(PLL_RST, s + 9, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'(PLL_RST));
    chk("arst_outs",  32'({pll_areset, sys_rst, ready, fail}), 32'(4'b1100));
    chk("arst_loss",  32'(lock_loss_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push(WAIT_LOCK, r + 4, 2'd0);
    push(STABLE, r + 5, 2'd0);
    push(RUN, r + 13, 2'd0);
    wait_drain(40);

    repeat (5) @(negedge clk);
    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
